// File: rtl/uart_pkg.sv
// Shared UART constants and the FIFO status layout used when mapping flags into a
// host-visible status register.
package uart_pkg;

  localparam int UART_DATA_WIDTH      = 8;
  localparam int UART_FIFO_ADDR_WIDTH = 4;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Dual-port FIFO storage: synchronous write, asynchronous read so the head word is
// visible in the same cycle it is addressed (first-word-fall-through).
module uart_fifo_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  w_en_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  output logic [DATA_WIDTH-1:0] r_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; the empty flag guards stale words.
  always_ff @(posedge clk_i) begin
    if (w_en_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/uart_fifo_buf.sv
// Synchronous FWFT FIFO between the UART serial engines and the host bus, with
// occupancy count, threshold flags and sticky overflow/underflow errors.
module uart_fifo_buf
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH   = UART_FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = AEMPTY_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_ok, rd_ok;
  fifo_status_t          status;

  // A write into a full FIFO is still legal when a read frees the head slot.
  assign wr_ok = wr && (!status.full || rd);
  assign rd_ok = rd && !status.empty;

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q && !clr_err;
    underflow_d = underflow_q && !clr_err;
    if (wr_ok) w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
    if (rd_ok) r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    if (wr && !wr_ok) overflow_d  = 1'b1;
    if (rd && !rd_ok) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    status              = '0;
    status.empty        = (count_q == '0);
    status.full         = (count_q == DEPTH_CNT);
    status.almost_empty = (count_q <= AEMPTY_CNT);
    status.almost_full  = (count_q >= AFULL_CNT);
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  // Storage writes are gated by reset so a push in the reset cycle leaves no trace.
  uart_fifo_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .w_en_i  (wr_ok && reset_n),
    .w_addr_i(w_ptr_q),
    .w_data_i(w_data),
    .r_addr_i(r_ptr_q),
    .r_data_o(r_data)
  );

  assign empty        = status.empty;
  assign full         = status.full;
  assign almost_empty = status.almost_empty;
  assign almost_full  = status.almost_full;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = count_q;

endmodule

// File: tb/tb_uart_fifo_buf.sv
// Directed bench for uart_fifo_buf: table of single-cycle vectors followed by
// hand-written full/wrap, overflow, and mid-operation reset sequences.
module tb_uart_fifo_buf;

  logic       clk;
  logic       reset_n;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full;
  logic [4:0] count;
  logic       overflow, underflow;
  logic       clr_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] data;
    logic       chkR;
    logic [7:0] expR;
    logic [4:0] expCount;
    logic       expEmpty;
    logic       expFull;
    logic       expAe;
    logic       expAf;
    logic       expOv;
    logic       expUf;
  } vecT;

  vecT vecs[14];

  uart_fifo_buf dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr          (wr),
    .w_data      (w_data),
    .rd          (rd),
    .r_data      (r_data),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int n, input logic expOv, input logic expUf);
    checkVal({tag, " count"}, 32'(count), 32'(n));
    checkVal({tag, " empty"}, 32'(empty), 32'(n == 0));
    checkVal({tag, " full"}, 32'(full), 32'(n == 16));
    checkVal({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= 2));
    checkVal({tag, " almost_full"}, 32'(almost_full), 32'(n >= 14));
    checkVal({tag, " overflow"}, 32'(overflow), 32'(expOv));
    checkVal({tag, " underflow"}, 32'(underflow), 32'(expUf));
  endtask

  // Inputs change on the falling edge; settled r_data is visible #1 later.
  task automatic applyStimulus(input logic w, input logic r, input logic c, input logic [7:0] d);
    @(negedge clk);
    wr      = w;
    rd      = r;
    clr_err = c;
    w_data  = d;
    #1;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    clr_err = 1'b0;
    w_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset count", 32'(count), 32'd0);
    checkVal("reset empty", 32'(empty), 32'd1);
    checkVal("reset full", 32'(full), 32'd0);
    checkVal("reset almost_empty", 32'(almost_empty), 32'd1);
    checkVal("reset almost_full", 32'(almost_full), 32'd0);
    checkVal("reset overflow", 32'(overflow), 32'd0);
    checkVal("reset underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    //            wr    rd    clr   data   chkR  expR   cnt   e     f     ae    af    ov    uf
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 8'h11, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 8'h11, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 8'h22, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h44, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].data);
      if (vecs[i].chkR) checkVal($sformatf("vec%0d r_data", i), 32'(r_data), 32'(vecs[i].expR));
      clockEdge();
      checkVal($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].expCount));
      checkVal($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].expEmpty));
      checkVal($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].expFull));
      checkVal($sformatf("vec%0d almost_empty", i), 32'(almost_empty), 32'(vecs[i].expAe));
      checkVal($sformatf("vec%0d almost_full", i), 32'(almost_full), 32'(vecs[i].expAf));
      checkVal($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].expOv));
      checkVal($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].expUf));
    end

    // Fill with 0x01..0x10; pointers start mid-array, so both wrap.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(i));
      clockEdge();
      checkOutput($sformatf("fill%0d", i), i, 1'b0, 1'b0);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 8'hAA);
    clockEdge();
    checkOutput("overflow push", 16, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    clockEdge();
    checkOutput("overflow hold", 16, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    clockEdge();
    checkOutput("overflow clear", 16, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
    checkVal("full rdwr r_data", 32'(r_data), 32'h01);
    clockEdge();
    checkOutput("full rdwr", 16, 1'b0, 1'b0);

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkVal($sformatf("drain%0d r_data", i), 32'(r_data), (i == 16) ? 32'h55 : 32'(i + 1));
      clockEdge();
      checkOutput($sformatf("drain%0d", i), 16 - i, 1'b0, 1'b0);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA1);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA2);
    clockEdge();
    checkOutput("pre-reset", 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA3);
    reset_n = 1'b0;
    clockEdge();
    checkOutput("mid reset", 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    reset_n = 1'b1;
    clockEdge();
    checkOutput("post reset idle", 0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h77);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h88);
    checkVal("post reset head", 32'(r_data), 32'h77);
    clockEdge();
    checkOutput("post reset push", 2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkVal("post reset pop1", 32'(r_data), 32'h77);
    clockEdge();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkVal("post reset pop2", 32'(r_data), 32'h88);
    clockEdge();
    checkOutput("post reset drained", 0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    clockEdge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
